// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing scheduler.
// Positions are numbered clockwise from north; counts are 5-bit tick counts.
package ped_pkg;

  localparam int COUNT_W = 5;

  localparam logic [1:0] POS_N = 2'd0;
  localparam logic [1:0] POS_E = 2'd1;
  localparam logic [1:0] POS_S = 2'd2;
  localparam logic [1:0] POS_W = 2'd3;

  typedef enum logic [1:0] {
    DARK    = 2'd0,
    ALL_RED = 2'd1,
    SERVE   = 2'd2
  } state_t;

  function automatic logic [3:0] pos_onehot(input logic [1:0] pos);
    return 4'b0001 << pos;
  endfunction

endpackage

// File: rtl/ped_rr_pick.sv
// Combinational 4-way rotating priority pick: first pending position after
// last, with last itself eligible only after the other three.
module ped_rr_pick (
  input  logic [3:0] pend,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] next
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending position wins.
  always_comb begin
    found = 1'b0;
    next  = last;
    idx   = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (pend[idx]) begin
        found = 1'b1;
        next  = idx;
      end
    end
  end

endmodule

// File: rtl/ped_phase_scheduler.sv
// Round-robin pedestrian phase sequencer: DARK / ALL_RED / SERVE, timed by tick.
// Request-to-walk latency is one clk when idle in ALL_RED; all outputs registered.
module ped_phase_scheduler
  import ped_pkg::*;
#(
  parameter int WALK_TIME    = 20,
  parameter int ALL_RED_TIME = 3,
  parameter int BLINK_START  = 3,
  parameter int SKIP_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               light_out_time,
  input  logic [3:0]         ped_req,
  output logic [1:0]         signal_Pos,
  output logic [COUNT_W-1:0] Count_out,
  output logic               signal,
  output logic [3:0]         walk,
  output logic [3:0]         req_pend
);

  localparam logic [COUNT_W-1:0] WALK_C    = COUNT_W'(WALK_TIME);
  localparam logic [COUNT_W-1:0] ALL_RED_C = COUNT_W'(ALL_RED_TIME);
  localparam logic [COUNT_W-1:0] BLINK_C   = COUNT_W'(BLINK_START);

  state_t     state;
  logic [3:0] pend_eff;
  logic       pick_found;
  logic [1:0] pick_pos;
  logic       go_found;
  logic [1:0] go_pos;
  logic       enter_serve;

  // Live requests take part in the pick so an idle crossing answers in one clk.
  assign pend_eff = req_pend | ped_req;

  ped_rr_pick u_pick (
    .pend  (pend_eff),
    .last  (signal_Pos),
    .found (pick_found),
    .next  (pick_pos)
  );

  assign go_found    = (SKIP_EN != 0) ? pick_found : 1'b1;
  assign go_pos      = (SKIP_EN != 0) ? pick_pos : signal_Pos + 2'd1;
  assign enter_serve = (state == ALL_RED) && (Count_out == '0) && go_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ALL_RED;
      signal_Pos <= POS_W;
      Count_out  <= ALL_RED_C;
      signal     <= 1'b0;
      walk       <= 4'b0000;
      req_pend   <= 4'b0000;
    end else if (light_out_time) begin
      state     <= DARK;
      Count_out <= '0;
      signal    <= 1'b0;
      walk      <= 4'b0000;
      req_pend  <= 4'b0000;
    end else begin
      req_pend <= enter_serve ? (pend_eff & ~pos_onehot(go_pos)) : pend_eff;
      case (state)
        DARK: begin
          state     <= ALL_RED;
          Count_out <= ALL_RED_C;
        end
        ALL_RED: begin
          if (Count_out != '0) begin
            if (tick) Count_out <= Count_out - 1'b1;
          end else if (go_found) begin
            state      <= SERVE;
            signal_Pos <= go_pos;
            Count_out  <= WALK_C;
            walk       <= pos_onehot(go_pos);
            signal     <= 1'b1;
          end
        end
        SERVE: begin
          if (tick) begin
            if (Count_out != '0) begin
              Count_out <= Count_out - 1'b1;
              // First count below threshold shows 1, then alternates per tick.
              signal    <= (Count_out >= BLINK_C) ? 1'b1 : ~signal;
            end else begin
              state     <= ALL_RED;
              Count_out <= ALL_RED_C;
              walk      <= 4'b0000;
              signal    <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ALL_RED;
          Count_out <= ALL_RED_C;
          walk      <= 4'b0000;
          signal    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_phase_scheduler.sv
// Directed bench: skipping instance for requests, blink and dark mode;
// non-skipping instance for fixed rotation and async reset.
module tb_ped_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst0 = 1'b1;
  logic       tick = 1'b0;
  logic       light = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] req0 = 4'b0000;

  logic [1:0] pos, pos0;
  logic [4:0] cnt, cnt0;
  logic       sig, sig0;
  logic [3:0] walk, walk0;
  logic [3:0] pend, pend0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ped_phase_scheduler #(.WALK_TIME(20), .ALL_RED_TIME(3), .BLINK_START(3), .SKIP_EN(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .light_out_time(light), .ped_req(req),
    .signal_Pos(pos), .Count_out(cnt), .signal(sig), .walk(walk), .req_pend(pend)
  );

  ped_phase_scheduler #(.WALK_TIME(20), .ALL_RED_TIME(3), .BLINK_START(3), .SKIP_EN(0)) dut0 (
    .clk(clk), .rst(rst0), .tick(tick), .light_out_time(light), .ped_req(req0),
    .signal_Pos(pos0), .Count_out(cnt0), .signal(sig0), .walk(walk0), .req_pend(pend0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic t);
    @(negedge clk);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic pulse(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
    req = 4'b0000;
  endtask

  task automatic next_serve();
    ticks(21);
    ticks(3);
    cyc(1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", cnt, 3);
    check("rst_pos", pos, 3);
    check("rst_walk", walk, 0);
    check("rst_sig", sig, 0);
    check("rst_pend", pend, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests: counts down, then parks at zero.
    ticks(2);
    check("idle_cnt1", cnt, 1);
    ticks(1);
    check("idle_cnt0", cnt, 0);
    repeat (5) cyc(1'b0);
    ticks(4);
    check("idle_hold_cnt", cnt, 0);
    check("idle_hold_walk", walk, 0);
    check("idle_hold_pos", pos, 3);

    // Single request served on the next clk.
    pulse(4'b0100);
    check("req2_pos", pos, 2);
    check("req2_walk", walk, 4'b0100);
    check("req2_cnt", cnt, 20);
    check("req2_pend", pend, 0);
    check("req2_sig", sig, 1);

    // Blink pattern near the end of SERVE.
    ticks(17);
    check("blink_c3_cnt", cnt, 3);
    check("blink_c3_sig", sig, 1);
    cyc(1'b1);
    check("blink_c2_sig", sig, 1);
    cyc(1'b1);
    check("blink_c1_sig", sig, 0);
    cyc(1'b1);
    check("blink_c0_cnt", cnt, 0);
    check("blink_c0_sig", sig, 1);
    cyc(1'b1);
    check("end_serve_cnt", cnt, 3);
    check("end_serve_walk", walk, 0);
    check("end_serve_sig", sig, 0);

    // Request latched during clearance, served after it.
    pulse(4'b0010);
    check("latch_pend", pend, 4'b0010);
    ticks(3);
    check("clear_walk", walk, 0);
    check("clear_cnt", cnt, 0);
    cyc(1'b0);
    check("rr1_pos", pos, 1);
    check("rr1_walk", walk, 4'b0010);
    check("rr1_pend", pend, 0);

    // Round-robin from position 1 with requests 1011.
    pulse(4'b1011);
    check("rr_pend", pend, 4'b1011);
    next_serve();
    check("rr_a_pos", pos, 3);
    check("rr_a_walk", walk, 4'b1000);
    check("rr_a_pend", pend, 4'b0011);
    next_serve();
    check("rr_b_pos", pos, 0);
    check("rr_b_pend", pend, 4'b0010);
    next_serve();
    check("rr_c_pos", pos, 1);
    check("rr_c_walk", walk, 4'b0010);
    check("rr_c_pend", pend, 0);
    next_serve();
    check("rr_idle_walk", walk, 0);
    check("rr_idle_cnt", cnt, 0);
    check("rr_idle_pos", pos, 1);

    // Dark mode mid-SERVE.
    pulse(4'b1000);
    check("dark_pre_pos", pos, 3);
    pulse(4'b0001);
    check("dark_pre_pend", pend, 4'b0001);
    ticks(8);
    check("dark_pre_cnt", cnt, 12);
    light = 1'b1;
    cyc(1'b0);
    check("dark_cnt", cnt, 0);
    check("dark_walk", walk, 0);
    check("dark_sig", sig, 0);
    check("dark_pend", pend, 0);
    pulse(4'b0100);
    check("dark_pend_held", pend, 0);
    ticks(2);
    check("dark_cnt_held", cnt, 0);
    light = 1'b0;
    cyc(1'b0);
    check("undark_cnt", cnt, 3);
    check("undark_pos", pos, 3);
    check("undark_walk", walk, 0);

    // Fixed rotation without skipping.
    check("ns_rst_pos", pos0, 3);
    check("ns_rst_cnt", cnt0, 3);
    @(negedge clk);
    rst0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ticks(3);
      cyc(1'b0);
      check("ns_pos", pos0, k % 4);
      check("ns_walk", walk0, 4'b0001 << (k % 4));
      check("ns_cnt", cnt0, 20);
      ticks(21);
      check("ns_ar_cnt", cnt0, 3);
      check("ns_ar_walk", walk0, 0);
    end
    ticks(3);
    cyc(1'b0);
    ticks(5);
    check("ns_mid_cnt", cnt0, 15);
    check("ns_mid_pos", pos0, 1);
    @(negedge clk);
    #2;
    rst0 = 1'b1;
    #1;
    check("async_rst_cnt", cnt0, 3);
    check("async_rst_pos", pos0, 3);
    check("async_rst_walk", walk0, 0);
    check("async_rst_sig", sig0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
